// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: controller state and
// the grouped register load/flush controls handed to the datapath.
package pipeline_ctrl_pkg;

  typedef enum logic {
    CTRL_INIT = 1'b0,
    CTRL_RUN  = 1'b1
  } ctrl_state_t;

  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_ex_mem;
  } pipe_ctrl_t;

  // Every register holds: a memory is still outstanding.
  localparam pipe_ctrl_t CTRL_HOLD = '0;

  // Every register loads a bubble: reset and the INIT cycle.
  localparam pipe_ctrl_t CTRL_FILL = '1;

  localparam pipe_ctrl_t CTRL_FLOW = '{
    load_pc: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1,
    load_ex_mem: 1'b1, load_mem_wb: 1'b1,
    flush_if_id: 1'b0, flush_id_ex: 1'b0, flush_ex_mem: 1'b0
  };

  // Taken branch/jump resolved in MEM squashes the three younger stages.
  localparam pipe_ctrl_t CTRL_REDIRECT = '{
    load_pc: 1'b1, load_if_id: 1'b1, load_id_ex: 1'b1,
    load_ex_mem: 1'b1, load_mem_wb: 1'b1,
    flush_if_id: 1'b1, flush_id_ex: 1'b1, flush_ex_mem: 1'b1
  };

  // Load-use: freeze PC and IF/ID, push a bubble into ID/EX, drain the rest.
  localparam pipe_ctrl_t CTRL_BUBBLE = '{
    load_pc: 1'b0, load_if_id: 1'b0, load_id_ex: 1'b1,
    load_ex_mem: 1'b1, load_mem_wb: 1'b1,
    flush_if_id: 1'b0, flush_id_ex: 1'b1, flush_ex_mem: 1'b0
  };

  function automatic logic load_use_hazard(
    input logic       ex_is_load,
    input logic [4:0] ex_rd,
    input logic [4:0] id_rs1,
    input logic [4:0] id_rs2,
    input logic       id_uses_rs1,
    input logic       id_uses_rs2
  );
    return ex_is_load && (ex_rd != 5'd0) &&
           ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
            (id_uses_rs2 && (id_rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_mem_resp_hold.sv
// Holds a single-cycle cache response until the whole pipeline can advance,
// so the faster memory does not lose its data while waiting for the other.
module mem_resp_hold (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resp,
  input  logic [31:0] rdata,
  input  logic        advance,
  output logic        done,
  output logic [31:0] data
);

  logic [31:0] hold_buf;

  // NOTE: the data buffer is reset along with the flag so a stale word can
  // never leak out after a reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done     <= 1'b0;
      hold_buf <= '0;
    end else if (advance) begin
      done <= 1'b0;
    end else if (resp && !done) begin
      // A second response while already holding is a protocol error; drop it.
      done     <= 1'b1;
      hold_buf <= rdata;
    end
  end

  assign data = done ? hold_buf : rdata;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage RV32I pipeline: combines the
// cache handshakes, load-use hazard and MEM redirect into register controls.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_resp,
  input  logic [31:0]      imem_rdata,
  output logic             imem_read,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic [31:0]      dmem_rdata,
  output logic             dmem_en,
  output logic [31:0]      if_instr,
  output logic [31:0]      mem_rdata,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             redirect,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state;
  pipe_ctrl_t  ctrl;
  logic        run;
  logic        imem_done;
  logic        dmem_done;
  logic        i_ok;
  logic        d_ok;
  logic        advance;
  logic        hz;

  // Reset is sampled synchronously, but while it is held the register
  // controls must already flood the pipeline with bubbles.
  assign run = rst_n && (state == CTRL_RUN);

  assign i_ok    = imem_done || imem_resp;
  assign d_ok    = !dmem_req || dmem_done || dmem_resp;
  assign advance = run && i_ok && d_ok;
  assign hz      = load_use_hazard(ex_is_load, ex_rd, id_rs1, id_rs2,
                                   id_uses_rs1, id_uses_rs2);

  assign imem_read = run && !imem_done;
  assign dmem_en   = run && dmem_req && !dmem_done;

  mem_resp_hold u_ihold (
    .clk     (clk),
    .rst_n   (rst_n),
    .resp    (imem_resp && run),
    .rdata   (imem_rdata),
    .advance (advance),
    .done    (imem_done),
    .data    (if_instr)
  );

  mem_resp_hold u_dhold (
    .clk     (clk),
    .rst_n   (rst_n),
    .resp    (dmem_resp && run),
    .rdata   (dmem_rdata),
    .advance (advance),
    .done    (dmem_done),
    .data    (mem_rdata)
  );

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    ctrl = CTRL_HOLD;
    if (!run) begin
      ctrl = CTRL_FILL;
    end else if (advance) begin
      if (redirect)  ctrl = CTRL_REDIRECT;
      else if (hz)   ctrl = CTRL_BUBBLE;
      else           ctrl = CTRL_FLOW;
    end
  end

  assign load_pc      = ctrl.load_pc;
  assign load_if_id   = ctrl.load_if_id;
  assign load_id_ex   = ctrl.load_id_ex;
  assign load_ex_mem  = ctrl.load_ex_mem;
  assign load_mem_wb  = ctrl.load_mem_wb;
  assign flush_if_id  = ctrl.flush_if_id;
  assign flush_id_ex  = ctrl.flush_id_ex;
  assign flush_ex_mem = ctrl.flush_ex_mem;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= CTRL_INIT;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        CTRL_INIT: state <= CTRL_RUN;
        CTRL_RUN: begin
          // A load-use bubble costs a cycle even though the back end moves.
          if (!advance || (hz && !redirect))
            stall_cnt <= stall_cnt + CNT_W'(1);
          if (advance && redirect)
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
        default: state <= CTRL_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of single-cycle vectors in RUN,
// plus hand sequences for reset/INIT and reset while a response is held.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        imem_read;
  logic        dmem_req;
  logic        dmem_resp;
  logic [31:0] dmem_rdata;
  logic        dmem_en;
  logic [31:0] if_instr;
  logic [31:0] mem_rdata;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_uses_rs1;
  logic        id_uses_rs2;
  logic        redirect;
  logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
  logic        flush_if_id, flush_id_ex, flush_ex_mem;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .imem_read    (imem_read),
    .dmem_req     (dmem_req),
    .dmem_resp    (dmem_resp),
    .dmem_rdata   (dmem_rdata),
    .dmem_en      (dmem_en),
    .if_instr     (if_instr),
    .mem_rdata    (mem_rdata),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_uses_rs1  (id_uses_rs1),
    .id_uses_rs2  (id_uses_rs2),
    .redirect     (redirect),
    .load_pc      (load_pc),
    .load_if_id   (load_if_id),
    .load_id_ex   (load_id_ex),
    .load_ex_mem  (load_ex_mem),
    .load_mem_wb  (load_mem_wb),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .flush_ex_mem (flush_ex_mem),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // Control byte: {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
  //                flush_if_id, flush_id_ex, flush_ex_mem}
  localparam logic [7:0] C_HOLD = 8'h00;
  localparam logic [7:0] C_ALL  = 8'hFF;
  localparam logic [7:0] C_FLOW = 8'hF8;
  localparam logic [7:0] C_BUB  = 8'h3A;

  typedef struct {
    logic        ir;
    logic [31:0] ird;
    logic        dq;
    logic        dr;
    logic [31:0] drd;
    logic        ld;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        u1;
    logic        u2;
    logic        red;
    logic [7:0]  e_ctrl;
    logic        e_iread;
    logic        e_den;
    logic [31:0] e_instr;
    logic [31:0] e_mrd;
    logic [31:0] e_stall;
    logic [31:0] e_flush;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ird,
    input logic dq, input logic dr, input logic [31:0] drd,
    input logic ld, input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic u1, input logic u2, input logic red,
    input logic [7:0] e_ctrl, input logic e_iread, input logic e_den,
    input logic [31:0] e_instr, input logic [31:0] e_mrd,
    input int e_stall, input int e_flush
  );
    vec_t v;
    v.ir = ir; v.ird = ird; v.dq = dq; v.dr = dr; v.drd = drd;
    v.ld = ld; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
    v.red = red; v.e_ctrl = e_ctrl; v.e_iread = e_iread; v.e_den = e_den;
    v.e_instr = e_instr; v.e_mrd = e_mrd;
    v.e_stall = 32'(e_stall); v.e_flush = 32'(e_flush);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ctrl_byte();
    return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
            flush_if_id, flush_id_ex, flush_ex_mem};
  endfunction

  task automatic drive(input vec_t v);
    imem_resp   = v.ir;  imem_rdata  = v.ird;
    dmem_req    = v.dq;  dmem_resp   = v.dr;  dmem_rdata = v.drd;
    ex_is_load  = v.ld;  ex_rd       = v.rd;
    id_rs1      = v.rs1; id_rs2      = v.rs2;
    id_uses_rs1 = v.u1;  id_uses_rs2 = v.u2;  redirect   = v.red;
  endtask

  // A response must only ever arrive while its request is outstanding.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_resp && !imem_read)) else $error("imem response while not requested");
      assert (!(dmem_resp && !dmem_en))   else $error("dmem response while not requested");
    end
  end

  initial begin
    vec_t idle;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Each row is one RUN cycle; counters are as seen before that cycle's edge.
    //        ir ird           dq dr drd           ld rd rs1 rs2 u1 u2 red ctrl   ird den instr         mrd           st fl
    vecs.push_back(mk(1, 32'h00500093, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_FLOW, 1, 0, 32'h00500093, 32'h0,        0, 0));
    vecs.push_back(mk(0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(1, 32'h00A00113, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 1, 32'h00A00113, 32'h0,        1, 0));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_HOLD, 0, 1, 32'h00A00113, 32'h0,        2, 0));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_HOLD, 0, 1, 32'h00A00113, 32'h0,        3, 0));
    vecs.push_back(mk(0, 32'hFFFFFFFF, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, C_FLOW, 0, 1, 32'h00A00113, 32'hDEADBEEF, 4, 0));
    vecs.push_back(mk(0, 32'h00000013, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0, 32'h00000013, 32'h0,        4, 0));
    // load-use on rs2, then the same with rd = x0
    vecs.push_back(mk(1, 32'h00000013, 1, 1, 32'h11223344, 1, 5, 0, 5, 0, 1, 0, C_BUB,  1, 1, 32'h00000013, 32'h11223344, 5, 0));
    vecs.push_back(mk(1, 32'h00000013, 1, 1, 32'h11223344, 1, 0, 0, 0, 0, 1, 0, C_FLOW, 1, 1, 32'h00000013, 32'h11223344, 6, 0));
    // rs1 match only counts when rs1 is actually read
    vecs.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,        1, 7, 7, 0, 0, 0, 0, C_FLOW, 1, 0, 32'h00000013, 32'h0,        6, 0));
    vecs.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,        1, 7, 7, 0, 1, 0, 0, C_BUB,  1, 0, 32'h00000013, 32'h0,        6, 0));
    // redirect wins over the hazard
    vecs.push_back(mk(1, 32'h00000013, 0, 0, 32'h0,        1, 7, 7, 0, 1, 0, 1, C_ALL,  1, 0, 32'h00000013, 32'h0,        7, 0));
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 0, 32'h0,        32'h0,        7, 1));
    // redirect without advance does nothing, then takes effect once fetch lands
    vecs.push_back(mk(0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, C_HOLD, 1, 0, 32'h0,        32'h0,        8, 1));
    vecs.push_back(mk(1, 32'h00000033, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 1, C_ALL,  1, 0, 32'h00000033, 32'h0,        9, 1));
    vecs.push_back(mk(1, 32'hCAFEF00D, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, C_HOLD, 1, 1, 32'hCAFEF00D, 32'h0,        9, 2));

    // Reset: controls flood while reset is held.
    drive(idle);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset ctrl", 32'(ctrl_byte()), 32'(C_ALL));
    check("reset imem_read", 32'(imem_read), 32'h0);

    // INIT cycle: exactly one cycle of bubbles with no memory traffic.
    rst_n = 1'b1;
    #1;
    check("init ctrl", 32'(ctrl_byte()), 32'(C_ALL));
    check("init imem_read", 32'(imem_read), 32'h0);
    check("init dmem_en", 32'(dmem_en), 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d ctrl", i),      32'(ctrl_byte()), 32'(vecs[i].e_ctrl));
      check($sformatf("v%0d imem_read", i), 32'(imem_read),   32'(vecs[i].e_iread));
      check($sformatf("v%0d dmem_en", i),   32'(dmem_en),     32'(vecs[i].e_den));
      check($sformatf("v%0d if_instr", i),  if_instr,         vecs[i].e_instr);
      check($sformatf("v%0d mem_rdata", i), mem_rdata,        vecs[i].e_mrd);
      check($sformatf("v%0d stall_cnt", i), stall_cnt,        vecs[i].e_stall);
      check($sformatf("v%0d flush_cnt", i), flush_cnt,        vecs[i].e_flush);
    end

    // Instruction is now held (imem_done) while the load is outstanding.
    @(negedge clk);
    drive(idle);
    dmem_req   = 1'b1;
    imem_rdata = 32'h0BADF00D;
    #1;
    check("held imem_read", 32'(imem_read), 32'h0);
    check("held if_instr", if_instr, 32'hCAFEF00D);
    check("held ctrl", 32'(ctrl_byte()), 32'(C_HOLD));
    check("held stall_cnt", stall_cnt, 32'd10);

    // Reset while the response is held: everything held is discarded.
    rst_n = 1'b0;
    #1;
    check("midreset ctrl", 32'(ctrl_byte()), 32'(C_ALL));
    @(negedge clk);
    rst_n      = 1'b1;
    dmem_req   = 1'b0;
    imem_rdata = 32'h12345678;
    #1;
    check("reinit ctrl", 32'(ctrl_byte()), 32'(C_ALL));
    check("reinit imem_read", 32'(imem_read), 32'h0);
    check("reinit if_instr", if_instr, 32'h12345678);
    check("reinit stall_cnt", stall_cnt, 32'h0);
    check("reinit flush_cnt", flush_cnt, 32'h0);

    @(negedge clk);
    #1;
    check("rerun imem_read", 32'(imem_read), 32'h1);
    check("rerun ctrl", 32'(ctrl_byte()), 32'(C_HOLD));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
